// File: rtl/test_card_pkg.sv
// Shared definitions for the test card generator: pattern modes, the 3-bit
// bar colour table and a helper that widens a 1-bit channel to full scale.
package test_card_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARES  = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_GRID     = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_e;

    // {r,g,b} per bar, bar 0 leftmost: white, yellow, cyan, green,
    // magenta, red, blue, black. Packed, so the last entry listed is index 0.
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000,  // 7 black
        3'b001,  // 6 blue
        3'b100,  // 5 red
        3'b101,  // 4 magenta
        3'b010,  // 3 green
        3'b011,  // 2 cyan
        3'b110,  // 1 yellow
        3'b111   // 0 white
    };

    // Full-scale (all ones) or zero; callers truncate to their channel width.
    function automatic logic [7:0] expand_bit(input logic b);
        return {8{b}};
    endfunction

endpackage

// File: rtl/test_card_anim.sv
// Animation state for the test card: a frame divider that advances the
// horizontal scroll offset once every SPEED frame strobes. A mode change
// restarts both counters so a new pattern always starts unscrolled.
module test_card_anim #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned SPEED = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_frame,
    input  logic        i_mode_chg,
    output logic [15:0] o_off
);

    localparam logic [15:0] FDIV_LAST = 16'(SPEED - 1);
    localparam logic [15:0] OFF_LAST  = 16'(H_RES - 1);

    logic [15:0] fdiv_q, fdiv_d;
    logic [15:0] off_q, off_d;

    // Next-state: count frames, step the offset on divider wrap.
    always_comb begin
        fdiv_d = fdiv_q;
        off_d  = off_q;
        if (i_frame) begin
            if (i_mode_chg) begin
                fdiv_d = '0;
                off_d  = '0;
            end else if (fdiv_q == FDIV_LAST) begin
                fdiv_d = '0;
                off_d  = (off_q == OFF_LAST) ? '0 : off_q + 16'd1;
            end else begin
                fdiv_d = fdiv_q + 16'd1;
            end
        end
    end

    // Counter registers; reset wins over a coincident frame strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fdiv_q <= '0;
            off_q  <= '0;
        end else begin
            fdiv_q <= fdiv_d;
            off_q  <= off_d;
        end
    end

    assign o_off = off_q;

endmodule

// File: rtl/test_card_gen.sv
// Test card generator: four selectable patterns (squares, bars, grid,
// gradient) with a two-stage pipeline from coordinates to registered RGB.
// Stage 1 registers the coordinate compares and scrolled x; stage 2
// registers colour. Define TEST_CARD_ANIM_EN to build the horizontal
// scroll animation; otherwise the scroll offset is tied to zero.
module test_card_gen
    import test_card_pkg::*;
#(
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480,
    parameter int unsigned COLR_BITS = 8,
    parameter int unsigned BW        = 16,
    parameter int unsigned GRID_LOG2 = 5,
    parameter int unsigned G_SHIFT   = 2,
    parameter int unsigned SPEED     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [15:0]          i_x,
    input  logic [15:0]          i_y,
    input  logic                 i_de,
    input  logic                 i_frame,
    input  logic [1:0]           i_mode,
    output logic [COLR_BITS-1:0] o_red,
    output logic [COLR_BITS-1:0] o_green,
    output logic [COLR_BITS-1:0] o_blue,
    output logic                 o_de,
    output logic [1:0]           o_mode
);

    localparam int unsigned SQ = V_RES >> 4;

    localparam logic [15:0] H_RES_W  = 16'(H_RES);
    localparam logic [15:0] V_RES_W  = 16'(V_RES);
    localparam logic [15:0] BW_W     = 16'(BW);
    localparam logic [15:0] H_BORDER = 16'(H_RES - BW);
    localparam logic [15:0] V_BORDER = 16'(V_RES - BW);
    localparam logic [15:0] SQ_SIDE  = 16'(4 * SQ);
    localparam logic [15:0] ROW_LO   = 16'((V_RES >> 1) - 2 * SQ);
    localparam logic [15:0] ROW_HI   = 16'((V_RES >> 1) + 2 * SQ);

    // ------------------------------------------------------------------
    // Mode latch and scroll offset
    // ------------------------------------------------------------------
    mode_e       mode_q;
    logic [15:0] off;

    // Pattern changes only take effect at frame boundaries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q <= MODE_SQUARES;
        end else if (i_frame) begin
            mode_q <= mode_e'(i_mode);
        end
    end

`ifdef TEST_CARD_ANIM_EN
    logic mode_chg;
    assign mode_chg = i_frame && (i_mode != mode_q);

    test_card_anim #(
        .H_RES (H_RES),
        .SPEED (SPEED)
    ) u_anim (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_frame    (i_frame),
        .i_mode_chg (mode_chg),
        .o_off      (off)
    );
`else
    assign off = '0;
`endif

    // ------------------------------------------------------------------
    // Stage 1: coordinate compares and scrolled x
    // ------------------------------------------------------------------
    logic [16:0]          xsum;
    logic [15:0]          xs;
    logic                 vis_d, border_d, square_d, grid_d;
    logic [2:0]           bar_idx_d;
    logic [COLR_BITS-1:0] grad_d;

    logic                 de_s1, vis_s1, border_s1, square_s1, grid_s1;
    logic [2:0]           bar_idx_s1;
    logic [COLR_BITS-1:0] grad_s1;
    mode_e                mode_s1;

    // Geometry decode for the current pixel, all patterns in parallel.
    always_comb begin
        xsum = {1'b0, i_x} + {1'b0, off};
        // off < H_RES, so one conditional subtract wraps any visible x.
        if (xsum >= {1'b0, H_RES_W}) begin
            xs = 16'(xsum - {1'b0, H_RES_W});
        end else begin
            xs = 16'(xsum);
        end

        vis_d = i_de && (i_x < H_RES_W) && (i_y < V_RES_W);

        border_d = (i_x < BW_W) || (i_x >= H_BORDER) ||
                   (i_y < BW_W) || (i_y >= V_BORDER);

        // Unscrolled x against the offset: the square slides off the right
        // edge instead of wrapping.
        square_d = ({1'b0, i_x} >= {1'b0, off}) &&
                   ({1'b0, i_x} < ({1'b0, off} + {1'b0, SQ_SIDE})) &&
                   (i_y >= ROW_LO) && (i_y < ROW_HI);

        // Bar index by threshold compares; thresholds ascend so the last
        // match is the bar number.
        bar_idx_d = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (xs >= 16'(k * (H_RES >> 3))) begin
                bar_idx_d = 3'(k);
            end
        end

        grid_d = (xs[GRID_LOG2-1:0] == '0) || (i_y[GRID_LOG2-1:0] == '0);

        grad_d = COLR_BITS'(i_x >> G_SHIFT);
    end

    // Stage 1 register; reset flushes in-flight pixels.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            de_s1      <= 1'b0;
            vis_s1     <= 1'b0;
            border_s1  <= 1'b0;
            square_s1  <= 1'b0;
            grid_s1    <= 1'b0;
            bar_idx_s1 <= '0;
            grad_s1    <= '0;
            mode_s1    <= MODE_SQUARES;
        end else begin
            de_s1      <= i_de;
            vis_s1     <= vis_d;
            border_s1  <= border_d;
            square_s1  <= square_d;
            grid_s1    <= grid_d;
            bar_idx_s1 <= bar_idx_d;
            grad_s1    <= grad_d;
            mode_s1    <= mode_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: colour select
    // ------------------------------------------------------------------
    logic [2:0]           rgb;
    logic                 use_grad;
    logic [COLR_BITS-1:0] red_d, green_d, blue_d;

    // Pick the pattern colour, then blank outside the active area.
    always_comb begin
        rgb      = 3'b000;
        use_grad = 1'b0;
        unique case (mode_s1)
            MODE_SQUARES:  rgb = border_s1 ? 3'b100 : (square_s1 ? 3'b111 : 3'b001);
            MODE_BARS:     rgb = BAR_RGB[bar_idx_s1];
            MODE_GRID:     rgb = grid_s1 ? 3'b111 : 3'b000;
            MODE_GRADIENT: use_grad = 1'b1;
            default:       rgb = 3'b000;
        endcase

        if (!vis_s1) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end else if (use_grad) begin
            red_d   = grad_s1;
            green_d = grad_s1;
            blue_d  = grad_s1;
        end else begin
            red_d   = COLR_BITS'(expand_bit(rgb[2]));
            green_d = COLR_BITS'(expand_bit(rgb[1]));
            blue_d  = COLR_BITS'(expand_bit(rgb[0]));
        end
    end

    // Stage 2 register drives the outputs directly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
            o_de    <= 1'b0;
        end else begin
            o_red   <= red_d;
            o_green <= green_d;
            o_blue  <= blue_d;
            o_de    <= de_s1;
        end
    end

    assign o_mode = mode_q;

endmodule
